// File: rtl/arf_iter.sv
// Iterative ARF graph evaluator: one graph level per clock across 8 BUSY steps,
// with saturating fixed-point arithmetic and an optional y -> s feedback state.
module arf_iter #(
  parameter int W     = 16,
  parameter int FRAC  = 0,
  parameter int FB_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [8*W-1:0]   in_data,
  input  logic [16*W-1:0]  coef,
  input  logic             st_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_data
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic signed [2*W-1:0] MAXV = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] MINV = {{(W+1){1'b1}}, {(W-1){1'b0}}};

  state_t              r_state, w_next;
  logic [2:0]          r_step;
  logic signed [W-1:0] r_a [8];
  logic signed [W-1:0] r_c [16];
  logic signed [W-1:0] r_v [8];
  logic signed [W-1:0] r_s0, r_s1, r_y0, r_y1;
  logic signed [W-1:0] w_y0, w_y1;

  function automatic logic signed [W-1:0] sat(input logic signed [2*W-1:0] x);
    if (x > MAXV)      sat = MAXV[W-1:0];
    else if (x < MINV) sat = MINV[W-1:0];
    else               sat = x[W-1:0];
  endfunction

  function automatic logic signed [W-1:0] add(input logic signed [W-1:0] x,
                                              input logic signed [W-1:0] y);
    logic signed [2*W-1:0] xe, ye;
    xe  = {{W{x[W-1]}}, x};
    ye  = {{W{y[W-1]}}, y};
    add = sat(xe + ye);
  endfunction

  function automatic logic signed [W-1:0] mul(input logic signed [W-1:0] x,
                                              input logic signed [W-1:0] y);
    logic signed [2*W-1:0] xe, ye, pr;
    xe  = {{W{x[W-1]}}, x};
    ye  = {{W{y[W-1]}}, y};
    pr  = xe * ye;
    pr  = pr >>> FRAC;
    mul = sat(pr);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_step  <= 3'd0;
    end else begin
      r_state <= w_next;
      r_step  <= (r_state == BUSY) ? r_step + 3'd1 : 3'd0;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = BUSY;
      end
      BUSY: if (r_step == 3'd7) w_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_y0     = add(r_v[0], r_v[1]);
  assign w_y1     = add(r_v[3], r_v[2]);
  assign out_data = {r_y1, r_y0};

  // r_v is a reused working file: v0/v3 keep n9/n12, v1/v2 carry the chain, v4-v7 hold products
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++)  r_a[i] <= '0;
      for (int i = 0; i < 16; i++) r_c[i] <= '0;
      for (int i = 0; i < 8; i++)  r_v[i] <= '0;
      r_s0 <= '0;
      r_s1 <= '0;
      r_y0 <= '0;
      r_y1 <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (st_clr) begin
            r_s0 <= '0;
            r_s1 <= '0;
          end
          if (in_valid) begin
            for (int i = 0; i < 8; i++)  r_a[i] <= in_data[i*W +: W];
            for (int i = 0; i < 16; i++) r_c[i] <= coef[i*W +: W];
          end
        end
        BUSY: begin
          case (r_step)
            3'd0: for (int i = 0; i < 8; i++) r_v[i] <= mul(r_a[i], r_c[i]);
            3'd1: begin
              r_v[0] <= add(r_v[0], r_v[1]);
              r_v[1] <= add(r_v[2], r_v[3]);
              r_v[2] <= add(r_v[4], r_v[5]);
              r_v[3] <= add(r_v[6], r_v[7]);
            end
            3'd2: begin
              r_v[1] <= add(r_v[1], r_s0);
              r_v[2] <= add(r_v[2], r_s1);
            end
            3'd3: begin
              r_v[4] <= mul(r_v[1], r_c[8]);
              r_v[5] <= mul(r_v[2], r_c[9]);
              r_v[6] <= mul(r_v[1], r_c[10]);
              r_v[7] <= mul(r_v[2], r_c[11]);
            end
            3'd5: begin
              r_v[4] <= mul(r_v[1], r_c[12]);
              r_v[5] <= mul(r_v[2], r_c[13]);
              r_v[6] <= mul(r_v[1], r_c[14]);
              r_v[7] <= mul(r_v[2], r_c[15]);
            end
            3'd4, 3'd6: begin
              r_v[1] <= add(r_v[4], r_v[5]);
              r_v[2] <= add(r_v[6], r_v[7]);
            end
            default: begin
              r_y0 <= w_y0;
              r_y1 <= w_y1;
              if (FB_EN != 0) begin
                r_s0 <= w_y0;
                r_s1 <= w_y1;
              end
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arf_iter.sv
// Bench for arf_iter: directed table, backpressure/reset/saturation sequences and
// randomized transactions checked against a plain-arithmetic graph model.
module tb_arf_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, st_clr, out_ready;
  logic [127:0] in_data;
  logic [255:0] coef;
  logic         rdy_a, rdy_b, rdy_c, ov_a, ov_b, ov_c;
  logic [31:0]  od_a, od_b, od_c;

  logic         s_in_valid, s_rdy, s_ov, s_out_ready;
  logic [63:0]  s_data;
  logic [127:0] s_coef;
  logic [15:0]  s_od;

  arf_iter #(.W(16), .FRAC(0), .FB_EN(1)) u_fb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a), .in_data(in_data),
    .coef(coef), .st_clr(st_clr), .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a));
  arf_iter #(.W(16), .FRAC(0), .FB_EN(0)) u_nofb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b), .in_data(in_data),
    .coef(coef), .st_clr(st_clr), .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b));
  arf_iter #(.W(16), .FRAC(4), .FB_EN(1)) u_frac (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_c), .in_data(in_data),
    .coef(coef), .st_clr(st_clr), .out_valid(ov_c), .out_ready(out_ready), .out_data(od_c));
  arf_iter #(.W(8), .FRAC(0), .FB_EN(1)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_rdy), .in_data(s_data),
    .coef(s_coef), .st_clr(1'b0), .out_valid(s_ov), .out_ready(s_out_ready), .out_data(s_od));

  int     nvec = 0;
  int     nfail = 0;
  longint ms0 [3];
  longint ms1 [3];
  int     mfrac [3] = '{0, 0, 4};
  bit     mfb [3]   = '{1'b1, 1'b0, 1'b1};

  typedef struct {
    logic [15:0] a;
    logic [15:0] c;
    bit          clr;
    longint      y_fb;
    longint      y_nofb;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input longint act, input longint exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint fld(input logic [255:0] v, input int idx, input int w);
    longint r;
    r = 0;
    for (int b = 0; b < w; b++) r[b] = v[idx*w + b];
    if (r[w-1]) r = r - (longint'(1) <<< w);
    return r;
  endfunction

  function automatic longint msat(input longint x, input int w);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic longint mmul(input longint x, input longint y, input int w, input int f);
    return msat((x * y) >>> f, w);
  endfunction

  task automatic model(input logic [255:0] d, input logic [255:0] cf, input int w, input int f,
                       input longint s0, input longint s1, output longint y0, output longint y1);
    longint p [8];
    longint n9, n10, n11, n12, n13, n14, n19, n20, n25, n26;
    for (int i = 0; i < 8; i++) p[i] = mmul(fld(d, i, w), fld(cf, i, w), w, f);
    n9  = msat(p[0] + p[1], w);
    n10 = msat(p[2] + p[3], w);
    n11 = msat(p[4] + p[5], w);
    n12 = msat(p[6] + p[7], w);
    n13 = msat(n10 + s0, w);
    n14 = msat(n11 + s1, w);
    n19 = msat(mmul(n13, fld(cf, 8, w), w, f) + mmul(n14, fld(cf, 9, w), w, f), w);
    n20 = msat(mmul(n13, fld(cf, 10, w), w, f) + mmul(n14, fld(cf, 11, w), w, f), w);
    n25 = msat(mmul(n19, fld(cf, 12, w), w, f) + mmul(n20, fld(cf, 13, w), w, f), w);
    n26 = msat(mmul(n19, fld(cf, 14, w), w, f) + mmul(n20, fld(cf, 15, w), w, f), w);
    y0  = msat(n9 + n25, w);
    y1  = msat(n12 + n26, w);
  endtask

  task automatic start(input logic [127:0] d, input logic [255:0] cf, input bit clr);
    chk("accept_ready", rdy_a, 1);
    in_data  = d;
    coef     = cf;
    st_clr   = clr;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    st_clr   = 1'b0;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    coef     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    chk("busy_not_ready", rdy_a, 0);
  endtask

  task automatic wait_done();
    int lat;
    lat = 1;
    while (!ov_a && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 9);
    chk("nofb_valid", ov_b, 1);
    chk("frac_valid", ov_c, 1);
  endtask

  task automatic expect_all(input logic [127:0] d, input logic [255:0] cf, input bit clr);
    longint y0, y1;
    logic [31:0] od;
    for (int k = 0; k < 3; k++) begin
      if (clr) begin
        ms0[k] = 0;
        ms1[k] = 0;
      end
      model({128'b0, d}, cf, 16, mfrac[k], ms0[k], ms1[k], y0, y1);
      od = (k == 0) ? od_a : (k == 1) ? od_b : od_c;
      chk($sformatf("model_y0_dut%0d", k), fld({224'b0, od}, 0, 16), y0);
      chk($sformatf("model_y1_dut%0d", k), fld({224'b0, od}, 1, 16), y1);
      ms0[k] = mfb[k] ? y0 : 0;
      ms1[k] = mfb[k] ? y1 : 0;
    end
  endtask

  task automatic finish_hs();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_after_hs_ready", rdy_a, 1);
    chk("idle_after_hs_valid", ov_a, 0);
  endtask

  task automatic txn(input logic [127:0] d, input logic [255:0] cf, input bit clr);
    start(d, cf, clr);
    wait_done();
    expect_all(d, cf, clr);
    finish_hs();
  endtask

  initial begin
    logic [127:0] d;
    logic [255:0] cf;
    logic [31:0]  hold;
    logic [31:0]  r;
    bit           stray;
    rst_n = 1'b0; in_valid = 1'b0; st_clr = 1'b0; out_ready = 1'b0;
    in_data = '0; coef = '0;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_data = '0; s_coef = '0;
    for (int k = 0; k < 3; k++) begin ms0[k] = 0; ms1[k] = 0; end

    tbl[0] = '{16'd1,      16'd1, 1'b0, 10,  10};
    tbl[1] = '{16'd1,      16'd1, 1'b0, 50,  10};
    tbl[2] = '{16'd1,      16'd1, 1'b1, 10,  10};
    tbl[3] = '{16'd2,      16'd1, 1'b0, 60,  20};
    tbl[4] = '{16'hFFFF,   16'd1, 1'b1, -10, -10};
    tbl[5] = '{16'd3,      16'd2, 1'b0, 44,  204};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", rdy_a, 1);
    chk("reset_out_valid", ov_a, 0);
    chk("reset_out_data", od_a, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      d  = {8{tbl[i].a}};
      cf = {16{tbl[i].c}};
      start(d, cf, tbl[i].clr);
      wait_done();
      chk($sformatf("tbl%0d_fb_y0", i), fld({224'b0, od_a}, 0, 16), tbl[i].y_fb);
      chk($sformatf("tbl%0d_fb_y1", i), fld({224'b0, od_a}, 1, 16), tbl[i].y_fb);
      chk($sformatf("tbl%0d_nofb_y0", i), fld({224'b0, od_b}, 0, 16), tbl[i].y_nofb);
      chk($sformatf("tbl%0d_nofb_y1", i), fld({224'b0, od_b}, 1, 16), tbl[i].y_nofb);
      expect_all(d, cf, tbl[i].clr);
      finish_hs();
    end

    // Backpressure: out_data held, input ignored while DONE
    d = {8{16'd1}}; cf = {16{16'd1}};
    start(d, cf, 1'b0);
    wait_done();
    hold = od_a;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      chk("bp_data_stable", od_a, hold);
      chk("bp_in_ready", rdy_a, 0);
      chk("bp_out_valid", ov_a, 1);
    end
    in_valid = 1'b0;
    expect_all(d, cf, 1'b0);
    finish_hs();
    stray = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (ov_a) stray = 1'b1;
    end
    chk("bp_no_stray_accept", stray, 0);

    // Reset in the middle of BUSY
    start(d, cf, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", rdy_a, 1);
    chk("midrst_out_valid", ov_a, 0);
    chk("midrst_out_data", od_a, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin ms0[k] = 0; ms1[k] = 0; end
    stray = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (ov_a) stray = 1'b1;
    end
    chk("midrst_no_stray_valid", stray, 0);
    start(d, cf, 1'b0);
    wait_done();
    chk("midrst_next_y0", fld({224'b0, od_a}, 0, 16), 10);
    expect_all(d, cf, 1'b0);
    finish_hs();

    // Saturation at W=8
    for (int i = 0; i < 2; i++) begin
      int lat;
      s_data = (i == 0) ? {8{8'd100}} : {8{8'h9C}};
      s_coef = {16{8'd100}};
      s_in_valid = 1'b1;
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      lat = 1;
      while (!s_ov && lat < 30) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("w8_latency", lat, 9);
      chk($sformatf("w8_sat%0d_y0", i), fld({240'b0, s_od}, 0, 8), (i == 0) ? 127 : -128);
      chk($sformatf("w8_sat%0d_y1", i), fld({240'b0, s_od}, 1, 8), (i == 0) ? 127 : -128);
      s_out_ready = 1'b1;
      @(posedge clk); #1;
      s_out_ready = 1'b0;
    end

    // Randomized transactions against the model
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 8; i++) begin
        r = $urandom;
        d[i*16 +: 16] = $urandom_range(0, 1) ? r[15:0] : 16'($urandom_range(0, 15)) - 16'd8;
      end
      for (int i = 0; i < 16; i++) begin
        r = $urandom;
        cf[i*16 +: 16] = $urandom_range(0, 1) ? r[15:0] : 16'($urandom_range(0, 31)) - 16'd12;
      end
      txn(d, cf, $urandom_range(0, 4) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
